// File: rtl/mdu_unit_if.sv
// Operand/result bundle between the E-stage forwarding muxes and the multiply/divide unit.
// The unit drives busy and the architectural HI/LO; the pipeline drives the launch request.
interface mdu_unit_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, op, a, b, input busy, hi, lo);
  modport slave  (input start, op, a, b, output busy, hi, lo);
endinterface

// File: rtl/mdu_unit.sv
// MIPS E-stage multiply/divide unit: multi-cycle MULT/MULTU/DIV/DIVU, MTHI/MTLO, HI/LO readout.
// Optional MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU accumulating into {hi,lo}.
module mdu_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic       clk,
  input logic       reset,
  mdu_unit_if.slave md
);

  localparam int MAXC  = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W = $clog2(MAXC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [3:0]         op_p0, op_nxt;
  logic [63:0]        pend_p0, pend_nxt;
  logic [31:0]        hi_q, lo_q, hi_nxt, lo_nxt;
  logic               is_mul, is_div, is_mac, sgn;
  logic [63:0]        mul_res, div_res, done_res;

  function automatic logic [63:0] mul_fn(input logic [31:0] x, input logic [31:0] y,
                                         input logic s);
    logic signed [63:0] ex, ey, p;
    ex = s ? $signed({{32{x[31]}}, x}) : $signed({32'd0, x});
    ey = s ? $signed({{32{y[31]}}, y}) : $signed({32'd0, y});
    p  = ex * ey;
    return p;
  endfunction

  // Returns {remainder, quotient}; zero divisor and INT_MIN/-1 are pinned explicitly.
  function automatic logic [63:0] div_fn(input logic [31:0] x, input logic [31:0] y,
                                         input logic s);
    logic signed [31:0] sx, sy, q, r;
    if (y == 32'd0) begin
      return {x, 32'hFFFF_FFFF};
    end else if (s && x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
      return {32'd0, 32'h8000_0000};
    end else if (s) begin
      sx = $signed(x);
      sy = $signed(y);
      q  = sx / sy;
      r  = sx % sy;
      return {r, q};
    end else begin
      return {x % y, x / y};
    end
  endfunction

  always_comb begin
    is_mul = (md.op == 4'd1) || (md.op == 4'd2);
    is_div = (md.op == 4'd3) || (md.op == 4'd4);
`ifdef MDU_MADD_EN
    is_mac = (md.op >= 4'd7) && (md.op <= 4'd10);
`else
    is_mac = 1'b0;
`endif
    sgn     = (md.op == 4'd1) || (md.op == 4'd3) || (md.op == 4'd7) || (md.op == 4'd9);
    mul_res = mul_fn(md.a, md.b, sgn);
    div_res = div_fn(md.a, md.b, sgn);
  end

  // Completion value: plain ops deliver the pending result, MAC ops fold it into current {hi,lo}.
  always_comb begin
    case (op_p0)
`ifdef MDU_MADD_EN
      4'd7, 4'd8:  done_res = {hi_q, lo_q} + pend_p0;
      4'd9, 4'd10: done_res = {hi_q, lo_q} - pend_p0;
`endif
      default:     done_res = pend_p0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    op_nxt    = op_p0;
    pend_nxt  = pend_p0;
    hi_nxt    = hi_q;
    lo_nxt    = lo_q;
    case (state)
      IDLE: begin
        if (md.start) begin
          if (is_mul || is_div || is_mac) begin
            op_nxt    = md.op;
            pend_nxt  = is_div ? div_res : mul_res;
            cnt_nxt   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
            state_nxt = RUN;
          end else if (md.op == 4'd5) begin
            hi_nxt = md.a;
          end else if (md.op == 4'd6) begin
            lo_nxt = md.a;
          end
        end
      end
      RUN: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          state_nxt        = IDLE;
          {hi_nxt, lo_nxt} = done_res;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Launch/completion stage boundary: every register clears on reset so an aborted op never lands.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      cnt     <= '0;
      op_p0   <= '0;
      pend_p0 <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      op_p0   <= op_nxt;
      pend_p0 <= pend_nxt;
      hi_q    <= hi_nxt;
      lo_q    <= lo_nxt;
    end
  end

  assign md.busy = (state == RUN);
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;

endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: scoreboard of expected HI/LO/latency, checked on busy release.
module tb_mdu_unit;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  typedef struct {
    string       tag;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } exp_t;

  exp_t sb[$];

  mdu_unit_if md ();

  mdu_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk   (clk),
    .reset (reset),
    .md    (md)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called just after a negedge; drives one start pulse and waits for busy to drop.
  task automatic go(input string tag, input logic [3:0] op, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                    input int ecyc, input bit inject);
    exp_t        e;
    int          n;
    logic [31:0] old_hi, old_lo;
    sb.push_back('{tag, ehi, elo, ecyc});
    old_hi   = md.hi;
    old_lo   = md.lo;
    md.start = 1'b1;
    md.op    = op;
    md.a     = a;
    md.b     = b;
    @(negedge clk);
    md.start = 1'b0;
    md.op    = 4'd0;
    md.a     = $urandom;
    md.b     = $urandom;
    n = 0;
    while (md.busy === 1'b1 && n < 200) begin
      if (n == 0) begin
        chk({tag, "_hold_hi"}, md.hi, old_hi);
        chk({tag, "_hold_lo"}, md.lo, old_lo);
      end
      if (inject) begin
        case (n)
          2: begin md.start = 1'b1; md.op = 4'd6; md.a = 32'd5; end
          5: begin md.start = 1'b1; md.op = 4'd1; md.a = 32'd9; md.b = 32'd9; end
          3, 6: begin md.start = 1'b0; md.op = 4'd0; end
          default: ;
        endcase
      end
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    chk({e.tag, "_cycles"}, 32'(n), 32'(e.cyc));
    chk({e.tag, "_hi"}, md.hi, e.hi);
    chk({e.tag, "_lo"}, md.lo, e.lo);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    reset    = 1'b0;
    md.start = 1'b0;
    md.op    = 4'd0;
    md.a     = 32'd0;
    md.b     = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'd0, md.busy}, 32'd0);
    chk("rst_hi", md.hi, 32'd0);
    chk("rst_lo", md.lo, 32'd0);
    reset = 1'b1;
    @(negedge clk);

    go("mult_neg",   4'd1, 32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, 5,  1'b0);
    go("multu_max",  4'd2, 32'hFFFF_FFFF, 32'd2,        32'h0000_0001, 32'hFFFF_FFFE, 5,  1'b0);
    go("mult_2neg",  4'd1, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h0,        32'h0000_000F, 5,  1'b0);
    go("div_neg",    4'd3, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 1'b0);
    go("divu_zero",  4'd4, 32'd7,         32'd0,        32'h0000_0007, 32'hFFFF_FFFF, 10, 1'b0);
    go("div_negdv",  4'd3, 32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 10, 1'b0);
    go("divu_plain", 4'd4, 32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E, 10, 1'b0);
    go("div_ovf",    4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 10, 1'b0);
    go("div_zero",   4'd3, 32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF, 10, 1'b0);
    go("mthi",       4'd5, 32'h1234_5678, 32'd0,        32'h1234_5678, 32'hFFFF_FFFF, 0,  1'b0);
    go("mtlo",       4'd6, 32'h0000_ABCD, 32'd0,        32'h1234_5678, 32'h0000_ABCD, 0,  1'b0);
    go("nop_op0",    4'd0, 32'd1,         32'd1,        32'h1234_5678, 32'h0000_ABCD, 0,  1'b0);
    go("nop_op11",   4'd11, 32'd1,        32'd1,        32'h1234_5678, 32'h0000_ABCD, 0,  1'b0);
    go("nop_op15",   4'd15, 32'd1,        32'd1,        32'h1234_5678, 32'h0000_ABCD, 0,  1'b0);
    go("div_inject", 4'd3, 32'd20,        32'd3,        32'h0000_0002, 32'h0000_0006, 10, 1'b1);

    // Abort a multiply with an asynchronous reset between clock edges.
    md.start = 1'b1;
    md.op    = 4'd1;
    md.a     = 32'd3;
    md.b     = 32'd4;
    @(negedge clk);
    md.start = 1'b0;
    md.op    = 4'd0;
    @(negedge clk);
    chk("abort_inflight", {31'd0, md.busy}, 32'd1);
    reset = 1'b0;
    #1;
    chk("abort_busy", {31'd0, md.busy}, 32'd0);
    chk("abort_hi", md.hi, 32'd0);
    chk("abort_lo", md.lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (8) @(negedge clk);
    chk("abort_after_busy", {31'd0, md.busy}, 32'd0);
    chk("abort_after_hi", md.hi, 32'd0);
    chk("abort_after_lo", md.lo, 32'd0);

    go("mthi_zero",  4'd5, 32'h0,         32'd0,        32'h0,         32'h0,         0,  1'b0);
    go("mtlo_ones",  4'd6, 32'hFFFF_FFFF, 32'd0,        32'h0,         32'hFFFF_FFFF, 0,  1'b0);
`ifdef MDU_MADD_EN
    go("maddu",      4'd8, 32'd1,         32'd1,        32'h0000_0001, 32'h0,         5,  1'b0);
    go("msub",       4'd9, 32'd2,         32'd3,        32'h0,         32'hFFFF_FFFA, 5,  1'b0);
    go("madd_neg",   4'd7, 32'hFFFF_FFFF, 32'd1,        32'h0,         32'hFFFF_FFF9, 5,  1'b0);
`else
    go("maddu_off",  4'd8, 32'd1,         32'd1,        32'h0,         32'hFFFF_FFFF, 0,  1'b0);
    go("msub_off",   4'd9, 32'd2,         32'd3,        32'h0,         32'hFFFF_FFFF, 0,  1'b0);
    go("madd_off",   4'd7, 32'hFFFF_FFFF, 32'd1,        32'h0,         32'hFFFF_FFFF, 0,  1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
